soc_periph_demux: RTL and testbench

- Single-master to NoSlv-slave request demultiplexer for the SoC peripheral/memory map.
- Sits between the core's uncached/cached bus master and the per-region slave ports (CLIC, DRAM, GPIO, Ethernet, SPI, Timer, UART, PLIC, CLINT, ROM, Debug).
- Decodes each request address against the fixed region table and forwards the request to the matching slave.
- Keeps responses in order by tracking outstanding transactions. Unmapped addresses go to an internal error responder.

---
 rtl/soc_periph_demux.sv | 130 +++++++++++++
 tb/tb_soc_periph_demux.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_periph_demux.sv
// Single-master to NoSlv-slave request demultiplexer with in-order response tracking.
// Unmapped addresses go to an internal error responder.
module soc_periph_demux #(
    parameter int unsigned NoSlv    = 11,
    parameter int unsigned MaxTrans = 4,
    parameter logic [NoSlv-1:0][63:0] AddrBase = {
        64'h0000_0000, 64'h0001_0000, 64'h0200_0000, 64'h0C00_0000,
        64'h1000_0000, 64'h1800_0000, 64'h2000_0000, 64'h3000_0000,
        64'h4000_0000, 64'h8000_0000, 64'h5000_0000
    },
    parameter logic [NoSlv-1:0][63:0] AddrLen = {
        64'h0000_1000, 64'h0001_0000, 64'h000C_0000, 64'h03FF_FFFF,
        64'h0000_1000, 64'h0000_1000, 64'h0080_0000, 64'h0001_0000,
        64'h0000_1000, 64'h4000_0000, 64'h03FF_FFFF
    }
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [63:0]           req_addr_i,
    input  logic                  req_we_i,
    input  logic [63:0]           req_wdata_i,
    input  logic [7:0]            req_strb_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [63:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [NoSlv-1:0]      slv_req_valid_o,
    input  logic [NoSlv-1:0]      slv_req_ready_i,
    output logic [63:0]           slv_addr_o,
    output logic                  slv_we_o,
    output logic [63:0]           slv_wdata_o,
    output logic [7:0]            slv_strb_o,
    input  logic [NoSlv-1:0]      slv_rsp_valid_i,
    output logic [NoSlv-1:0]      slv_rsp_ready_o,
    input  logic [NoSlv*64-1:0]   slv_rsp_rdata_i,
    input  logic [NoSlv-1:0]      slv_rsp_err_i
);

    localparam int unsigned SelW = $clog2(NoSlv + 1);
    localparam int unsigned CntW = $clog2(MaxTrans + 1);
    localparam logic [SelW-1:0] Err    = SelW'(NoSlv);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxTrans);

    logic [SelW-1:0] sel_q;
    logic [CntW-1:0] cnt_q;
    logic [SelW-1:0] tgt;
    logic            hit;
    logic            can_issue;
    logic            accept;
    logic            rsp_hs;

    assign slv_addr_o  = req_addr_i;
    assign slv_we_o    = req_we_i;
    assign slv_wdata_o = req_wdata_i;
    assign slv_strb_o  = req_strb_i;

    // 65-bit compare so base+len never wraps; first hit (lowest index) wins.
    always_comb begin
        tgt = Err;
        hit = 1'b0;
        for (int unsigned i = 0; i < NoSlv; i++) begin
            if (!hit && ({1'b0, req_addr_i} >= {1'b0, AddrBase[i]}) &&
                ({1'b0, req_addr_i} < ({1'b0, AddrBase[i]} + {1'b0, AddrLen[i]}))) begin
                tgt = SelW'(i);
                hit = 1'b1;
            end
        end
    end

    always_comb begin
        can_issue       = rst_ni && ((cnt_q == '0) || (tgt == sel_q)) && (cnt_q < CntMax);
        slv_req_valid_o = '0;
        req_ready_o     = 1'b0;
        for (int unsigned i = 0; i < NoSlv; i++) begin
            if (tgt == SelW'(i)) begin
                slv_req_valid_o[i] = req_valid_i && can_issue;
                req_ready_o        = can_issue && slv_req_ready_i[i];
            end
        end
        if (tgt == Err) begin
            req_ready_o = can_issue;
        end
    end

    always_comb begin
        rsp_valid_o     = 1'b0;
        rsp_rdata_o     = '0;
        rsp_err_o       = 1'b0;
        slv_rsp_ready_o = '0;
        if (cnt_q != '0) begin
            if (sel_q == Err) begin
                rsp_valid_o = 1'b1;
                rsp_err_o   = 1'b1;
            end else begin
                for (int unsigned i = 0; i < NoSlv; i++) begin
                    if (sel_q == SelW'(i)) begin
                        rsp_valid_o        = slv_rsp_valid_i[i];
                        slv_rsp_ready_o[i] = rsp_ready_i;
                        if (slv_rsp_valid_i[i]) begin
                            rsp_rdata_o = slv_rsp_rdata_i[64*i +: 64];
                            rsp_err_o   = slv_rsp_err_i[i];
                        end
                    end
                end
            end
        end
    end

    assign accept = req_valid_i && req_ready_o;
    assign rsp_hs = rsp_valid_o && rsp_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel_q <= '0;
            cnt_q <= '0;
        end else begin
            if (accept) begin
                sel_q <= tgt;
            end
            if (accept && !rsp_hs) begin
                cnt_q <= cnt_q + CntW'(1);
            end else if (!accept && rsp_hs) begin
                cnt_q <= cnt_q - CntW'(1);
            end
        end
    end

endmodule

// File: tb/tb_soc_periph_demux.sv
// Randomized and directed bench for soc_periph_demux against a queue-based
// reference model of the region map and in-order outstanding transactions.
module tb_soc_periph_demux;

    localparam int unsigned NoSlv    = 11;
    localparam int unsigned MaxTrans = 4;
    localparam int unsigned ErrIdx   = NoSlv;

    logic                 clk;
    logic                 rst_n;
    logic                 req_valid;
    logic                 req_ready;
    logic [63:0]          req_addr;
    logic                 req_we;
    logic [63:0]          req_wdata;
    logic [7:0]           req_strb;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [63:0]          rsp_rdata;
    logic                 rsp_err;
    logic [NoSlv-1:0]     slv_req_valid;
    logic [NoSlv-1:0]     slv_req_ready;
    logic [63:0]          slv_addr;
    logic                 slv_we;
    logic [63:0]          slv_wdata;
    logic [7:0]           slv_strb;
    logic [NoSlv-1:0]     slv_rsp_valid;
    logic [NoSlv-1:0]     slv_rsp_ready;
    logic [NoSlv*64-1:0]  slv_rsp_rdata;
    logic [NoSlv-1:0]     slv_rsp_err;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    // Memory map: index order CLIC, DRAM, GPIO, Eth, SPI, Timer, UART, PLIC, CLINT, ROM, Debug.
    logic [63:0] map_base [NoSlv] = '{
        64'h5000_0000, 64'h8000_0000, 64'h4000_0000, 64'h3000_0000, 64'h2000_0000,
        64'h1800_0000, 64'h1000_0000, 64'h0C00_0000, 64'h0200_0000, 64'h0001_0000,
        64'h0000_0000
    };
    logic [63:0] map_len [NoSlv] = '{
        64'h03FF_FFFF, 64'h4000_0000, 64'h0000_1000, 64'h0001_0000, 64'h0080_0000,
        64'h0000_1000, 64'h0000_1000, 64'h03FF_FFFF, 64'h000C_0000, 64'h0001_0000,
        64'h0000_1000
    };
    logic [63:0] addr_pool [17] = '{
        64'h5000_0000, 64'h53FF_FFFE, 64'h53FF_FFFF, 64'h4000_0FFF, 64'h3000_8000,
        64'h2000_0010, 64'h1800_0FFF, 64'h1000_0008, 64'h0C00_0004, 64'h0200_BFF8,
        64'h0001_FFFF, 64'h0000_0FFF, 64'h0000_1000, 64'h6000_0000, 64'hC000_0000,
        64'hFFFF_FFFF_FFFF_FFF8, 64'h0002_0000
    };

    // Targets of accepted-but-unanswered requests, oldest first.
    int unsigned outq [$];

    soc_periph_demux #(
        .NoSlv    (NoSlv),
        .MaxTrans (MaxTrans)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_addr_i      (req_addr),
        .req_we_i        (req_we),
        .req_wdata_i     (req_wdata),
        .req_strb_i      (req_strb),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .rsp_rdata_o     (rsp_rdata),
        .rsp_err_o       (rsp_err),
        .slv_req_valid_o (slv_req_valid),
        .slv_req_ready_i (slv_req_ready),
        .slv_addr_o      (slv_addr),
        .slv_we_o        (slv_we),
        .slv_wdata_o     (slv_wdata),
        .slv_strb_o      (slv_strb),
        .slv_rsp_valid_i (slv_rsp_valid),
        .slv_rsp_ready_o (slv_rsp_ready),
        .slv_rsp_rdata_i (slv_rsp_rdata),
        .slv_rsp_err_i   (slv_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned ref_decode(input logic [63:0] a);
        for (int i = 0; i < NoSlv; i++) begin
            if (a >= map_base[i] && (a - map_base[i]) < map_len[i]) return i;
        end
        return ErrIdx;
    endfunction

    task automatic idle_inputs();
        req_valid     = 1'b0;
        req_addr      = '0;
        req_we        = 1'b0;
        req_wdata     = '0;
        req_strb      = '0;
        rsp_ready     = 1'b0;
        slv_req_ready = '0;
        slv_rsp_valid = '0;
        slv_rsp_rdata = '0;
        slv_rsp_err   = '0;
    endtask

    task automatic rand_inputs();
        req_valid = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 9) < 4)
            req_addr = 64'h8000_0000 + {32'h0, $urandom & 32'h3FFF_FFF8};
        else
            req_addr = addr_pool[$urandom_range(0, 16)];
        req_we    = $urandom_range(0, 1) == 1;
        req_wdata = {$urandom, $urandom};
        req_strb  = 8'($urandom);
        rsp_ready = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < NoSlv; i++) begin
            slv_req_ready[i] = ($urandom_range(0, 3) != 0);
            slv_rsp_valid[i] = ($urandom_range(0, 1) == 1);
            slv_rsp_err[i]   = ($urandom_range(0, 7) == 0);
            slv_rsp_rdata[64*i +: 64] = {$urandom, $urandom};
        end
    endtask

    // Inputs are already driven; compare outputs, advance the model, move to the next cycle.
    task automatic step();
        int unsigned t;
        int unsigned head;
        bit          can;
        logic [NoSlv-1:0] exp_sv, exp_sr;
        logic        exp_rdy, exp_rv, exp_err;
        logic [63:0] exp_rd;
        #2;
        t   = ref_decode(req_addr);
        can = (outq.size() == 0 || outq[0] == t) && outq.size() < MaxTrans;
        exp_sv = '0;
        if (t < NoSlv) exp_sv[t] = req_valid && can;
        exp_rdy = can && ((t == ErrIdx) ? 1'b1 : slv_req_ready[t]);
        exp_sr  = '0;
        exp_rv  = 1'b0;
        exp_err = 1'b0;
        exp_rd  = '0;
        if (outq.size() > 0) begin
            head = outq[0];
            if (head == ErrIdx) begin
                exp_rv  = 1'b1;
                exp_err = 1'b1;
            end else begin
                exp_rv       = slv_rsp_valid[head];
                exp_sr[head] = rsp_ready;
                exp_rd       = slv_rsp_rdata[64*head +: 64];
                exp_err      = slv_rsp_err[head];
            end
        end
        check_eq("req_ready", {63'h0, req_ready}, {63'h0, exp_rdy});
        check_eq("slv_req_valid", 64'(slv_req_valid), 64'(exp_sv));
        check_eq("rsp_valid", {63'h0, rsp_valid}, {63'h0, exp_rv});
        check_eq("slv_rsp_ready", 64'(slv_rsp_ready), 64'(exp_sr));
        if (exp_rv) begin
            check_eq("rsp_rdata", rsp_rdata, exp_rd);
            check_eq("rsp_err", {63'h0, rsp_err}, {63'h0, exp_err});
        end
        check_eq("slv_addr", slv_addr, req_addr);
        check_eq("slv_wdata", slv_wdata, req_wdata);
        check_eq("slv_we_strb", {55'h0, slv_we, slv_strb}, {55'h0, req_we, req_strb});
        if (exp_rv && rsp_ready) void'(outq.pop_front());
        if (req_valid && exp_rdy) outq.push_back(t);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_ready"}, {63'h0, req_ready}, 64'h0);
        check_eq({tag, "_slv_req_valid"}, 64'(slv_req_valid), 64'h0);
        check_eq({tag, "_rsp_valid"}, {63'h0, rsp_valid}, 64'h0);
        check_eq({tag, "_rsp_rdata"}, rsp_rdata, 64'h0);
        check_eq({tag, "_rsp_err"}, {63'h0, rsp_err}, 64'h0);
        check_eq({tag, "_slv_rsp_ready"}, 64'(slv_rsp_ready), 64'h0);
    endtask

    task automatic req_only(input logic [63:0] a, input logic we);
        idle_inputs();
        req_valid     = 1'b1;
        req_addr      = a;
        req_we        = we;
        req_wdata     = {32'hA5A5_0000, a[31:0]};
        req_strb      = 8'hFF;
        slv_req_ready = '1;
    endtask

    task automatic drain(input int unsigned slv);
        for (int n = 0; n < 8; n++) begin
            idle_inputs();
            rsp_ready = 1'b1;
            if (slv < NoSlv) begin
                slv_rsp_valid[slv] = 1'b1;
                slv_rsp_rdata[64*slv +: 64] = 64'h1111_0000 + 64'(n);
            end
            step();
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        // Aggressive inputs during reset must not leak through.
        req_valid     = 1'b1;
        req_addr      = 64'h8000_0000;
        slv_req_ready = '1;
        slv_rsp_valid = '1;
        rsp_ready     = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        check_reset_outputs("reset");
        idle_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // UART read returning 0xDEAD_BEEF.
        req_only(64'h1000_0008, 1'b0);
        step();
        idle_inputs();
        rsp_ready        = 1'b1;
        slv_rsp_valid[6] = 1'b1;
        slv_rsp_rdata[64*6 +: 64] = 64'hDEAD_BEEF;
        step();
        idle_inputs();
        step();

        // Unmapped read goes to the error responder with one-cycle latency.
        req_only(64'h6000_0000, 1'b0);
        slv_req_ready = '0;
        step();
        idle_inputs();
        rsp_ready = 1'b1;
        step();
        step();

        // Four DRAM writes fill the tracker; the fifth stalls, even while a response completes.
        for (int unsigned k = 0; k < 5; k++) begin
            req_only(64'h8000_0000 + 64'(8 * k), 1'b1);
            step();
        end
        req_only(64'h8000_0020, 1'b1);
        rsp_ready        = 1'b1;
        slv_rsp_valid[1] = 1'b1;
        step();
        req_only(64'h8000_0020, 1'b1);
        step();
        drain(1);

        // Target switch waits for the outstanding DRAM read to complete.
        req_only(64'h8000_0100, 1'b0);
        step();
        for (int unsigned k = 0; k < 2; k++) begin
            req_only(64'h0200_0000, 1'b0);
            step();
        end
        req_only(64'h0200_0000, 1'b0);
        rsp_ready        = 1'b1;
        slv_rsp_valid[1] = 1'b1;
        step();
        req_only(64'h0200_0000, 1'b0);
        step();
        drain(8);

        // Region boundaries.
        req_only(64'hBFFF_FFFF, 1'b0); step(); drain(1);
        req_only(64'hC000_0000, 1'b0); step(); drain(ErrIdx);
        req_only(64'h0000_0FFF, 1'b0); step(); drain(10);
        req_only(64'h0000_1000, 1'b0); step(); drain(ErrIdx);

        for (int n = 0; n < 3000; n++) begin
            rand_inputs();
            step();
        end
        drain(ErrIdx);
        for (int s = 0; s < NoSlv; s++) drain(s);

        // Asynchronous reset with three DRAM requests outstanding.
        for (int unsigned k = 0; k < 3; k++) begin
            req_only(64'h8000_0200 + 64'(8 * k), 1'b1);
            step();
        end
        req_only(64'h8000_0300, 1'b1);
        slv_rsp_valid = '1;
        rsp_ready     = 1'b1;
        rst_n         = 1'b0;
        #1;
        check_reset_outputs("midreset");
        outq.delete();
        @(posedge clk);
        #1;
        idle_inputs();
        rst_n = 1'b1;
        req_only(64'h0001_0000, 1'b0);
        step();
        drain(9);

        for (int n = 0; n < 1000; n++) begin
            rand_inputs();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
